// File: rtl/root_dispatcher.sv
// Request front-end for the nth-root engine: queues tagged requests, launches
// them one at a time and returns tagged results with an error code.
module root_dispatcher #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_radicand,
    input  logic [2:0]  req_degree,
    input  logic [3:0]  req_tag,
    output logic        eng_in_valid,
    output logic [9:0]  eng_in_data_1,
    output logic [2:0]  eng_in_data_2,
    input  logic        eng_out_valid,
    input  logic [19:0] eng_out_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [19:0] rsp_root,
    output logic [3:0]  rsp_tag,
    output logic [1:0]  rsp_err,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_DEG = 2'b01;
    localparam logic [1:0] ERR_TO  = 2'b10;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DRAIN, RESP} state_t;

    typedef struct packed {
        logic [3:0] tag;
        logic [2:0] degree;
        logic [9:0] radicand;
    } req_t;

    req_t          mem [FIFO_DEPTH];
    req_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] timer;
    logic [CW-1:0] timer_n;
    logic          out_valid_q;
    logic          result_edge;
    logic          legal;
    logic          launch_n;
    logic          rsp_valid_n;
    logic [19:0]   rsp_root_n;
    logic [1:0]    rsp_err_n;

    assign empty       = (count == '0);
    assign full        = (count == FULL);
    assign req_ready   = !full;
    assign push        = req_valid && !full;
    assign head        = mem[rd_ptr];
    assign legal       = (head.degree != 3'd0) && (head.degree <= 3'd5);
    assign result_edge = eng_out_valid && !out_valid_q;
    assign busy        = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{tag: req_tag, degree: req_degree,
                             radicand: req_radicand};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        pop         = 1'b0;
        launch_n    = 1'b0;
        rsp_valid_n = rsp_valid;
        rsp_root_n  = rsp_root;
        rsp_err_n   = rsp_err;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (legal) begin
                        state_n  = LAUNCH;
                        launch_n = 1'b1;
                    end else begin
                        state_n     = RESP;
                        rsp_valid_n = 1'b1;
                        rsp_root_n  = '0;
                        rsp_err_n   = ERR_DEG;
                    end
                end
            end
            LAUNCH: begin
                state_n = WAIT;
                timer_n = '0;
            end
            WAIT: begin
                timer_n = timer + 1'b1;
                // A result arriving on the last allowed cycle beats the timeout
                if (result_edge) begin
                    state_n    = DRAIN;
                    rsp_root_n = eng_out_data;
                    rsp_err_n  = ERR_OK;
                end else if (timer == LAST) begin
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                    rsp_root_n  = '0;
                    rsp_err_n   = ERR_TO;
                end
            end
            DRAIN: begin
                if (!eng_out_valid) begin
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Engine operands stay put until the next pop; the engine reads them late
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer         <= '0;
            out_valid_q   <= 1'b0;
            eng_in_valid  <= 1'b0;
            eng_in_data_1 <= '0;
            eng_in_data_2 <= '0;
            rsp_valid     <= 1'b0;
            rsp_root      <= '0;
            rsp_tag       <= '0;
            rsp_err       <= '0;
        end else begin
            timer        <= timer_n;
            out_valid_q  <= eng_out_valid;
            eng_in_valid <= launch_n;
            rsp_valid    <= rsp_valid_n;
            rsp_root     <= rsp_root_n;
            rsp_err      <= rsp_err_n;
            if (pop) begin
                eng_in_data_1 <= head.radicand;
                eng_in_data_2 <= head.degree;
                rsp_tag       <= head.tag;
            end
        end
    end

endmodule

// File: tb/tb_root_dispatcher.sv
// Bench for root_dispatcher: directed scenarios plus a randomized run checked
// against a request-level model of expected responses.
module tb_root_dispatcher;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_radicand;
    logic [2:0]  req_degree;
    logic [3:0]  req_tag;
    logic        eng_in_valid;
    logic [9:0]  eng_in_data_1;
    logic [2:0]  eng_in_data_2;
    logic        eng_out_valid = 1'b0;
    logic [19:0] eng_out_data  = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [19:0] rsp_root;
    logic [3:0]  rsp_tag;
    logic [1:0]  rsp_err;
    logic        busy;

    root_dispatcher #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(63)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_radicand(req_radicand), .req_degree(req_degree), .req_tag(req_tag),
        .eng_in_valid(eng_in_valid), .eng_in_data_1(eng_in_data_1),
        .eng_in_data_2(eng_in_data_2),
        .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_root(rsp_root), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] root;
        logic [3:0]  tag;
        logic [1:0]  err;
    } rsp_t;

    rsp_t got[$];
    rsp_t exp_q[$];
    int   n_asserts = 0;
    int   n_fail = 0;

    // Stub engine: a radicand of 3FF is never answered
    int   stub_delay = 25;
    int   stub_len = 2;
    bit   stub_fixed = 1'b0;
    int   cd = -1;
    int   hold = 0;
    int   pulses = 0;
    int   hold_bad = 0;
    logic [9:0] cap1 = '0;
    logic [2:0] cap2 = '0;

    function automatic logic [19:0] stub_fn(input logic [9:0] r, input logic [2:0] d);
        return {r, 7'h55, d};
    endfunction

    function automatic rsp_t model(input logic [9:0] r, input logic [2:0] d,
                                   input logic [3:0] t);
        rsp_t m;
        m.tag = t;
        if (d < 3'd1 || d > 3'd5) begin
            m.err = 2'b01; m.root = '0;
        end else if (r == 10'h3FF) begin
            m.err = 2'b10; m.root = '0;
        end else begin
            m.err = 2'b00; m.root = stub_fn(r, d);
        end
        return m;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            cd = -1;
            hold = 0;
            eng_out_valid = 1'b0;
        end else begin
            if (cd > 0 || hold > 0) begin
                if (eng_in_data_1 !== cap1 || eng_in_data_2 !== cap2) hold_bad++;
            end
            if (eng_in_valid) begin
                pulses++;
                cap1 = eng_in_data_1;
                cap2 = eng_in_data_2;
                cd = (eng_in_data_1 == 10'h3FF) ? -1 : stub_delay;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    eng_out_valid = 1'b1;
                    eng_out_data = stub_fixed ? 20'hABCDE : stub_fn(cap1, cap2);
                    hold = stub_len;
                    cd = -1;
                end
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) eng_out_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) got.push_back({rsp_root, rsp_tag, rsp_err});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [9:0] r, input logic [2:0] d, input logic [3:0] t);
        bit ok;
        ok = 1'b0;
        req_radicand = r;
        req_degree = d;
        req_tag = t;
        req_valid = 1'b1;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #2;
        end
        req_valid = 1'b0;
        chk("push_accept", 32'(ok), 1);
        if (ok) exp_q.push_back(model(r, d, t));
    endtask

    task automatic wait_rsp(input int n, input int bound);
        int k;
        k = 0;
        while (got.size() < n && k < bound) begin
            step(1);
            k++;
        end
        chk("rsp_count", got.size(), n);
    endtask

    task automatic compare_all(input string tag);
        rsp_t g;
        rsp_t e;
        while (got.size() > 0) begin
            g = got.pop_front();
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{root: 20'hFFFFF, tag: 4'hF, err: 2'b11};
            chk({tag, "_root"}, 32'(g.root), 32'(e.root));
            chk({tag, "_tag"}, 32'(g.tag), 32'(e.tag));
            chk({tag, "_err"}, 32'(g.err), 32'(e.err));
        end
        chk({tag, "_leftover"}, exp_q.size(), 0);
    endtask

    initial begin
        int p0;
        int p1;
        int k;
        int bad;
        logic [19:0] r0;
        logic [3:0]  t0;
        logic [1:0]  e0;
        logic [9:0]  rr;
        logic [2:0]  rd;
        logic [3:0]  rt;

        rst = 1'b1;
        req_valid = 1'b0;
        req_radicand = '0;
        req_degree = '0;
        req_tag = '0;
        rsp_ready = 1'b1;
        step(3);
        chk("rst_in_valid", 32'(eng_in_valid), 0);
        chk("rst_in_data_1", 32'(eng_in_data_1), 0);
        chk("rst_in_data_2", 32'(eng_in_data_2), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_root", 32'(rsp_root), 0);
        chk("rst_rsp_tag", 32'(rsp_tag), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        rst = 1'b0;
        step(2);

        // single request with fixed engine data
        p0 = pulses;
        stub_fixed = 1'b1;
        stub_delay = 25;
        stub_len = 2;
        push(10'd100, 3'd2, 4'h3);
        exp_q[exp_q.size() - 1].root = 20'hABCDE;
        @(negedge clk);
        chk("launch_early", 32'(eng_in_valid), 0);
        @(negedge clk);
        chk("launch_pulse", 32'(eng_in_valid), 1);
        chk("in_data_1", 32'(eng_in_data_1), 100);
        chk("in_data_2", 32'(eng_in_data_2), 2);
        @(negedge clk);
        chk("launch_one_cycle", 32'(eng_in_valid), 0);
        step(1);
        wait_rsp(1, 200);
        chk("single_pulses", pulses - p0, 1);
        chk("single_hold", hold_bad, 0);
        chk("single_data_kept", 32'(eng_in_data_1), 100);
        compare_all("single");
        stub_fixed = 1'b0;

        // illegal degrees
        p0 = pulses;
        push(10'd55, 3'd0, 4'h7);
        @(negedge clk);
        chk("illegal_early", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("illegal_rsp_valid", 32'(rsp_valid), 1);
        step(1);
        push(10'd56, 3'd6, 4'h8);
        wait_rsp(2, 50);
        chk("illegal_no_launch", pulses - p0, 0);
        compare_all("illegal");

        // FIFO fill while the engine is busy
        p0 = pulses;
        stub_delay = 40;
        stub_len = 1;
        push(10'd200, 3'd3, 4'h1);
        step(5);
        push(10'd201, 3'd4, 4'h2);
        push(10'd202, 3'd5, 4'h3);
        push(10'd203, 3'd1, 4'h4);
        push(10'd204, 3'd2, 4'h5);
        @(negedge clk);
        chk("fill_ready_low", 32'(req_ready), 0);
        chk("fill_busy", 32'(busy), 1);
        step(1);
        push(10'd205, 3'd1, 4'h6);
        wait_rsp(6, 600);
        chk("fill_pulses", pulses - p0, 6);
        compare_all("fill");

        // timeout, then the queued request still launches
        p0 = pulses;
        stub_delay = 10;
        stub_len = 2;
        push(10'h3FF, 3'd2, 4'hA);
        push(10'd77, 3'd3, 4'hB);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!eng_in_valid && k < 100);
        chk("to_launch_seen", 32'(eng_in_valid), 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 200);
        chk("to_latency", k, 64);
        chk("to_err", 32'(rsp_err), 2);
        chk("to_root", 32'(rsp_root), 0);
        step(1);
        wait_rsp(2, 200);
        chk("to_pulses", pulses - p0, 2);
        compare_all("timeout");

        // response back-pressure
        p0 = pulses;
        stub_delay = 5;
        stub_len = 1;
        rsp_ready = 1'b0;
        push(10'd300, 3'd4, 4'hC);
        push(10'd301, 3'd5, 4'hD);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 100);
        chk("bp_rsp_valid", 32'(rsp_valid), 1);
        chk("bp_root", 32'(rsp_root), 32'(stub_fn(10'd300, 3'd4)));
        r0 = rsp_root;
        t0 = rsp_tag;
        e0 = rsp_err;
        p1 = pulses;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_root !== r0 || rsp_tag !== t0 || rsp_err !== e0 || !rsp_valid) bad++;
        end
        chk("bp_stable", bad, 0);
        chk("bp_no_launch", pulses - p1, 0);
        chk("bp_busy", 32'(busy), 1);
        step(1);
        rsp_ready = 1'b1;
        wait_rsp(2, 200);
        chk("bp_pulses", pulses - p0, 2);
        compare_all("backpressure");

        // reset while waiting with two requests queued
        p0 = pulses;
        push(10'h3FF, 3'd1, 4'h2);
        push(10'd10, 3'd2, 4'h4);
        push(10'd11, 3'd3, 4'h5);
        step(8);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_valid", 32'(eng_in_valid), 0);
        chk("mid_rst_in_data_1", 32'(eng_in_data_1), 0);
        chk("mid_rst_in_data_2", 32'(eng_in_data_2), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_rsp_root", 32'(rsp_root), 0);
        chk("mid_rst_rsp_tag", 32'(rsp_tag), 0);
        chk("mid_rst_rsp_err", 32'(rsp_err), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_req_ready", 32'(req_ready), 1);
        exp_q.delete();
        step(2);
        rst = 1'b0;
        p1 = pulses;
        step(150);
        chk("rst_no_rsp", got.size(), 0);
        chk("rst_idle", 32'(busy), 0);
        chk("rst_no_launch", pulses - p1, 0);
        chk("rst_pulses", pulses - p0, 1);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            rr = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 1022));
            rd = 3'($urandom);
            rt = 4'($urandom);
            stub_delay = $urandom_range(1, 20);
            stub_len = $urandom_range(1, 3);
            rsp_ready = 1'b1;
            push(rr, rd, rt);
            repeat ($urandom_range(0, 6)) begin
                rsp_ready = 1'($urandom);
                step(1);
            end
        end
        rsp_ready = 1'b1;
        wait_rsp(exp_q.size(), 6000);
        compare_all("random");
        chk("final_hold", hold_bad, 0);
        step(3);
        chk("final_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
